uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 153 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a small byte FIFO.
// The serial line is driven from a register so it never glitches between bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       o,
  output logic       busy
);

  localparam int              AW          = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]     FULL_COUNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]     EMPTY_COUNT = (AW+1)'(0);
  localparam logic [AW:0]     COUNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_ONE     = AW'(1);
  localparam logic [15:0]     BAUD_LAST   = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [7:0]      mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic [15:0]     baud_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic            push_s;
  logic            pop_s;
  logic            baud_done_s;

  assign tx_ready = (count_r != FULL_COUNT);
  assign busy     = (state_r != IDLE) || (count_r != EMPTY_COUNT);

  // Handshake and pop decode; a pop only happens at a frame boundary.
  always_comb begin
    push_s      = tx_valid && tx_ready;
    baud_done_s = (baud_r == BAUD_LAST);
    pop_s       = 1'b0;
    case (state_r)
      IDLE:    pop_s = (count_r != EMPTY_COUNT);
      STOP:    pop_s = baud_done_s && (count_r != EMPTY_COUNT);
      default: pop_s = 1'b0;
    endcase
  end

  // FIFO storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_data;
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= EMPTY_COUNT;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + COUNT_ONE;
        2'b01:   count_r <= count_r - COUNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencer; o is loaded together with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      o         <= 1'b1;
      baud_r    <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          o <= 1'b1;
          if (pop_s) begin
            shift_r   <= mem_r[rd_ptr_r];
            baud_r    <= 16'd0;
            bit_idx_r <= 3'd0;
            state_r   <= START;
            o         <= 1'b0;
          end
        end
        START: begin
          if (baud_done_s) begin
            baud_r  <= 16'd0;
            state_r <= DATA;
            o       <= shift_r[0];
          end else begin
            baud_r <= baud_r + 16'd1;
          end
        end
        DATA: begin
          if (baud_done_s) begin
            baud_r <= 16'd0;
            if (bit_idx_r == 3'd7) begin
              state_r <= STOP;
              o       <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              o         <= shift_r[1];
            end
          end else begin
            baud_r <= baud_r + 16'd1;
          end
        end
        STOP: begin
          if (baud_done_s) begin
            baud_r <= 16'd0;
            if (pop_s) begin
              shift_r   <= mem_r[rd_ptr_r];
              bit_idx_r <= 3'd0;
              state_r   <= START;
              o         <= 1'b0;
            end else begin
              state_r <= IDLE;
              o       <= 1'b1;
            end
          end else begin
            baud_r <= baud_r + 16'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          o       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame-timeline model checked every cycle,
// a line decoder, and hand-computed expectations for each directed scenario.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       o;
  logic       busy;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .o(o), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bytes waiting in the FIFO, plus the frame on the line and how far into it we are.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_push;
  bit         m_pop;

  function automatic logic frame_bit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      m_push = tx_valid && (mq.size() != DEPTH);
      m_pop  = (mq.size() > 0) && (!m_active || m_t == FRAME - 1);
      if (m_active && m_t != FRAME - 1) begin
        m_t++;
      end else if (m_pop) begin
        m_cur    = mq.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_active = 1'b0;
      end
      if (m_push) mq.push_back(tx_data);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("o_vs_model", o, m_active ? frame_bit(m_cur, m_t / CPB) : 1'b1);
    check("busy_vs_model", busy, m_active || (mq.size() != 0));
    check("tx_ready_vs_model", tx_ready, mq.size() != DEPTH);
  end

  // Line decoder: samples mid-bit and collects received bytes.
  logic [7:0] rx_q[$];
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_bits = 10'd0;

  always @(negedge clk) begin
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (o == 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) rx_bits[rx_cnt / CPB] = o;
      if (rx_cnt == FRAME - CPB / 2) begin
        check("rx_start_bit", rx_bits[0], 1'b0);
        check("rx_stop_bit", rx_bits[9], 1'b1);
        rx_q.push_back(rx_bits[8:1]);
        rx_on = 1'b0;
      end
    end
  end

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_rx(input string name, input logic [7:0] exp[$]);
    check({name, "_count"}, rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
      check(name, rx_q[i], exp[i]);
    end
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] exp_q[$];
    int n;
    int acc;
    int guard;
    bit will_accept;
    bit seen_full;
    bit back_checked;

    repeat (3) @(negedge clk);
    check("reset_o", o, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_tx_ready", tx_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    // Single 0x55 frame with exact bit timing.
    rx_q.delete();
    pat = 10'b1010101010;
    tx_valid = 1'b1; tx_data = 8'h55;
    @(negedge clk);
    tx_valid = 1'b0;
    check("busy_after_push", busy, 1'b1);
    check("o_before_start", o, 1'b1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      check("frame55_bit", o, pat[k / CPB]);
    end
    check("busy_in_last_stop_cycle", busy, 1'b1);
    @(negedge clk);
    check("busy_after_frame", busy, 1'b0);
    exp_q = '{8'h55};
    check_rx("rx55", exp_q);

    // Three back-to-back frames with no idle gap.
    rx_q.delete();
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge clk); tx_data = 8'h3C;
    @(negedge clk); tx_data = 8'hFF;
    @(negedge clk); tx_valid = 1'b0;
    count_busy(n);
    check("b2b_busy_cycles", n, 119);
    exp_q = '{8'hA5, 8'h3C, 8'hFF};
    check_rx("rx_b2b", exp_q);

    // Streaming with tx_valid held high: back-pressure and refused push when full.
    rx_q.delete();
    acc = 0; guard = 0; seen_full = 1'b0; back_checked = 1'b0;
    tx_valid = 1'b1; tx_data = 8'h00;
    while (acc < 10 && guard < 3000) begin
      will_accept = tx_ready;
      @(negedge clk);
      guard++;
      if (will_accept) begin
        acc++;
        tx_data = tx_data + 8'd1;
      end
      if (acc == 10) tx_valid = 1'b0;
      if (!tx_ready && !seen_full) begin
        seen_full = 1'b1;
        check("accepted_when_full", acc, 5);
      end
      if (seen_full && tx_ready && !back_checked) begin
        back_checked = 1'b1;
        check("count_after_refused_push", mq.size(), 3);
      end
    end
    tx_valid = 1'b0;
    check("stream_accepted", acc, 10);
    check("stream_saw_full", seen_full, 1'b1);
    check("stream_saw_refill", back_checked, 1'b1);
    count_busy(n);
    check("stream_drained", busy, 1'b0);
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    check_rx("rx_stream", exp_q);

    // tx_valid pulse while full must be ignored.
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      tx_valid = 1'b1; tx_data = 8'h10 + 8'(i);
      @(negedge clk);
    end
    check("full_before_pulse", tx_ready, 1'b0);
    tx_valid = 1'b1; tx_data = 8'hEE;
    @(negedge clk);
    tx_valid = 1'b0;
    check("full_after_pulse", tx_ready, 1'b0);
    count_busy(n);
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_rx("rx_pulse", exp_q);

    // Reset mid-frame, then a clean frame afterwards.
    rx_q.delete();
    tx_valid = 1'b1; tx_data = 8'h81;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("busy_mid_frame", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_o", o, 1'b1);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rx_after_abort", rx_q.size(), 0);
    tx_valid = 1'b1; tx_data = 8'h81;
    @(negedge clk);
    tx_valid = 1'b0;
    count_busy(n);
    check("frame81_busy_cycles", n, FRAME + 1);
    exp_q = '{8'h81};
    check_rx("rx81", exp_q);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
